alu_wb_stage: RTL and testbench
===============================

// Module: alu_wb_stage
// PURPOSE
//   Registered writeback stage downstream of the 16-bit ALU (AND/NOT/ADD/SAT).
//   - Captures each ALU result with its destination tag and op code.
//   - Computes LC-3 style condition codes N/Z/P for each result.
//   - Holds results in a 2-entry skid buffer with a valid/ready handshake toward
//     the register-file write port.
//   - Keeps the architectural CC register, updated as each entry retires.
// PARAMETERS
//   WIDTH   16  data width; must match the ALU result width
//   TAGW    3   destination register tag width (8 GPRs)
// PORTS
//   clk         in   1      single clock; all state updates on posedge
//   reset       in   1      synchronous, active-high
//   in_valid    in   1      ALU result presented this cycle
//   in_ready    out  1      stage can accept a result this cycle
//   in_result   in   WIDTH  ALU output
//   in_op       in   2      ALU select: 00 AND, 01 NOT, 10 ADD, 11 SAT
//   in_dest     in   TAGW   destination register tag
//   in_setcc    in   1      1 = this result updates the CC register on retire
//   out_valid   out  1      head entry available
//   out_ready   in   1      consumer takes the head entry this cycle
//   out_result  out  WIDTH  head entry result
//   out_dest    out  TAGW   head entry tag
//   out_op      out  2      head entry op
//   cc          out  3      architectural {N,Z,P}
// BEHAVIOUR
//   - push = in_valid & in_ready; pop = out_valid & out_ready.
//   - Occupancy state machine: EMPTY(0) / ONE(1) / TWO(2).
//       EMPTY: push -> ONE
//       ONE:   push & !pop -> TWO; pop & !push -> EMPTY;
//              push & pop -> ONE, with the new entry becoming the head
//       TWO:   pop -> ONE, slot 1 moves to the head; push impossible
//   - in_ready = (state != TWO). It is a registered function of state and
//     never depends combinationally on out_ready.
//   - out_valid = (state != EMPTY). out_* come straight from the head
//     registers, with no combinational path from in_* to out_*.
//   - Latency: a result pushed in cycle t is visible on out_* in cycle t+1
//     when the buffer was empty.
//   - Ordering is strict FIFO: no drop, no duplicate, no reordering.
//   - Per-entry CC is computed at push from in_result:
//       N = in_result[WIDTH-1]
//       Z = (in_result == 0)
//       P = !N & !Z
//     Exactly one bit is ever set. The CC is stored with the entry.
//   - On pop of an entry with setcc=1: cc <= entry CC on the next edge.
//     On pop with setcc=0, cc is unchanged.
//   - When out_valid=1 and out_ready=0, the head entry and out_* hold stable
//     until the pop.
//   - Reset (synchronous, any cycle, including mid-transfer):
//       state = EMPTY, in_ready = 1, out_valid = 0,
//       out_result = 0, out_dest = 0, out_op = 0, cc = 3'b010 (Z).
//     A push or pop coincident with reset is discarded.
//   - While reset is asserted, in_valid is ignored.
// TESTING
//   1. Reset with in_valid=1 -> next cycle out_valid=0, in_ready=1, cc=010,
//      out_result=0000.
//   2. Push ADD 0x0f0f+0xf0f0 = 0xffff, dest 3, setcc=1; out_ready=1 ->
//      out_result=ffff, out_dest=3 at t+1; cc=100 one cycle after the pop.
//   3. out_ready=0; push 0x4444 (AND), then 0x3333 (NOT) -> in_ready=0 after
//      the 2nd push; a 3rd in_valid is refused; then out_ready=1 -> 4444 then
//      3333 out in order.
//   4. State ONE holding 0x0000 (setcc=1), push 0x7f7f (SAT) with pop in the
//      same cycle -> stays ONE, head=7f7f, cc=010.
//   5. Pop an entry with setcc=0 and result 0x8000 -> cc unchanged from its
//      prior value (001).
//   6. State TWO with out_ready=1, assert reset for one cycle -> EMPTY, no
//      entry emitted afterwards, cc=010.

Source files
------------

// File: rtl/alu_wb_stage.sv
// Registered writeback stage behind the 16-bit ALU: a 2-entry skid buffer with
// per-entry N/Z/P condition codes and the architectural CC register.
module alu_wb_stage #(
    parameter int WIDTH = 16,
    parameter int TAGW  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [1:0]       in_op,
    input  logic [TAGW-1:0]  in_dest,
    input  logic             in_setcc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAGW-1:0]  out_dest,
    output logic [1:0]       out_op,
    output logic [2:0]       cc
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [TAGW-1:0]  dest;
        logic [1:0]       op;
        logic             setcc;
        logic [2:0]       nzp;
    } entry_t;

    occ_state_t state_q, state_d;
    entry_t     head_q, slot_q, new_entry;
    logic [2:0] cc_q;
    logic       push, pop;
    logic       res_neg, res_zero;

    // Handshake depends only on registered occupancy, never on out_ready.
    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign res_neg  = in_result[WIDTH-1];
    assign res_zero = (in_result == '0);

    always_comb begin
        new_entry.result = in_result;
        new_entry.dest   = in_dest;
        new_entry.op     = in_op;
        new_entry.setcc  = in_setcc;
        new_entry.nzp    = {res_neg, res_zero, !res_neg && !res_zero};
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_d; otherwise a latch is inferred.
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (pop && !push) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: entry storage is reset because the head drives out_* directly and must read zero.
            head_q <= '0;
            slot_q <= '0;
            cc_q   <= 3'b010;
        end else begin
            // NOTE: non-blocking so the pop of the old head and its CC use pre-edge values.
            if (pop && head_q.setcc) cc_q <= head_q.nzp;
            case (state_q)
                EMPTY: if (push) head_q <= new_entry;
                ONE: begin
                    // Simultaneous push and pop: the old head leaves, the new entry takes its place.
                    if (push && pop) head_q <= new_entry;
                    else if (push)   slot_q <= new_entry;
                end
                TWO:     if (pop) head_q <= slot_q;
                default: ;
            endcase
        end
    end

    assign out_result = head_q.result;
    assign out_dest   = head_q.dest;
    assign out_op     = head_q.op;
    assign cc         = cc_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: directed scenarios with literal
// expectations, then random traffic against a queue-based reference model.
module tb_alu_wb_stage;

    localparam int WIDTH = 16;
    localparam int TAGW  = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_result = '0;
    logic [1:0]       in_op = '0;
    logic [TAGW-1:0]  in_dest = '0;
    logic             in_setcc = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [TAGW-1:0]  out_dest;
    logic [1:0]       out_op;
    logic [2:0]       cc;

    int n_checks = 0;
    int n_errors = 0;

    alu_wb_stage #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_op      (in_op),
        .in_dest    (in_dest),
        .in_setcc   (in_setcc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_dest   (out_dest),
        .out_op     (out_op),
        .cc         (cc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two entries plus the CC value.
    typedef struct {
        logic [WIDTH-1:0] result;
        logic [TAGW-1:0]  dest;
        logic [1:0]       op;
        logic             setcc;
    } item_t;

    item_t      model_q[$];
    logic [2:0] model_cc = 3'b010;
    bit         model_live = 0;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
        if (v == 0)             return 3'b010;
        else if (v[WIDTH-1])    return 3'b100;
        else                    return 3'b001;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            model_q.delete();
            model_cc   = 3'b010;
            model_live = 1;
        end else if (model_live) begin
            bit   do_push, do_pop;
            item_t it;
            do_push = in_valid && (model_q.size() < 2);
            do_pop  = (model_q.size() > 0) && out_ready;
            if (do_pop) begin
                it = model_q.pop_front();
                if (it.setcc) model_cc = nzp_of(it.result);
            end
            if (do_push) begin
                it.result = in_result;
                it.dest   = in_dest;
                it.op     = in_op;
                it.setcc  = in_setcc;
                model_q.push_back(it);
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("m_out_valid", {31'b0, out_valid}, {31'b0, model_q.size() != 0});
            check("m_in_ready", {31'b0, in_ready}, {31'b0, model_q.size() < 2});
            check("m_cc", {29'b0, cc}, {29'b0, model_cc});
            if (model_q.size() != 0) begin
                check("m_out_result", {16'b0, out_result}, {16'b0, model_q[0].result});
                check("m_out_dest", {29'b0, out_dest}, {29'b0, model_q[0].dest});
                check("m_out_op", {30'b0, out_op}, {30'b0, model_q[0].op});
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] r, input logic [1:0] op,
                         input logic [TAGW-1:0] d, input logic s);
        in_valid  = v;
        in_result = r;
        in_op     = op;
        in_dest   = d;
        in_setcc  = s;
    endtask

    initial begin
        // 1: reset with in_valid high
        drive(1'b1, 16'h1234, 2'b10, 3'd7, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_cc", {29'b0, cc}, 32'b010);
        check("rst_out_result", {16'b0, out_result}, 32'h0);

        // 2: ADD result 0xffff, dest 3, setcc
        out_ready = 1'b1;
        drive(1'b1, 16'hffff, 2'b10, 3'd3, 1'b1);
        cycle();
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0);
        check("s2_out_valid", {31'b0, out_valid}, 32'd1);
        check("s2_out_result", {16'b0, out_result}, 32'hffff);
        check("s2_out_dest", {29'b0, out_dest}, 32'd3);
        check("s2_cc_before", {29'b0, cc}, 32'b010);
        cycle();
        check("s2_cc_after", {29'b0, cc}, 32'b100);
        check("s2_empty", {31'b0, out_valid}, 32'd0);

        // 3: fill both slots, third push refused, drain in order
        out_ready = 1'b0;
        drive(1'b1, 16'h4444, 2'b00, 3'd1, 1'b0);
        cycle();
        drive(1'b1, 16'h3333, 2'b01, 3'd2, 1'b0);
        cycle();
        check("s3_full_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1'b1, 16'h5555, 2'b10, 3'd6, 1'b0);
        cycle();
        check("s3_refused_in_ready", {31'b0, in_ready}, 32'd0);
        check("s3_head0", {16'b0, out_result}, 32'h4444);
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0);
        out_ready = 1'b1;
        cycle();
        check("s3_head1", {16'b0, out_result}, 32'h3333);
        check("s3_head1_op", {30'b0, out_op}, 32'd1);
        cycle();
        check("s3_drained", {31'b0, out_valid}, 32'd0);
        check("s3_cc", {29'b0, cc}, 32'b100);

        // 4: ONE holding 0x0000 (setcc), push 0x7f7f with simultaneous pop
        out_ready = 1'b0;
        drive(1'b1, 16'h0000, 2'b00, 3'd4, 1'b1);
        cycle();
        out_ready = 1'b1;
        drive(1'b1, 16'h7f7f, 2'b11, 3'd5, 1'b1);
        cycle();
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0);
        check("s4_valid", {31'b0, out_valid}, 32'd1);
        check("s4_in_ready", {31'b0, in_ready}, 32'd1);
        check("s4_head", {16'b0, out_result}, 32'h7f7f);
        check("s4_cc", {29'b0, cc}, 32'b010);
        cycle();
        check("s4_cc_pos", {29'b0, cc}, 32'b001);

        // 5: pop of 0x8000 with setcc=0 leaves cc alone
        drive(1'b1, 16'h8000, 2'b10, 3'd0, 1'b0);
        cycle();
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0);
        cycle();
        check("s5_cc_kept", {29'b0, cc}, 32'b001);

        // 6: reset while full with out_ready high
        out_ready = 1'b0;
        drive(1'b1, 16'h8001, 2'b10, 3'd1, 1'b1);
        cycle();
        drive(1'b1, 16'h8002, 2'b10, 3'd2, 1'b1);
        cycle();
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0);
        out_ready = 1'b1;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("s6_empty", {31'b0, out_valid}, 32'd0);
        check("s6_cc", {29'b0, cc}, 32'b010);
        check("s6_in_ready", {31'b0, in_ready}, 32'd1);
        cycle();
        cycle();
        check("s6_no_emit", {31'b0, out_valid}, 32'd0);
        check("s6_cc_hold", {29'b0, cc}, 32'b010);

        // Random traffic, with corner-case results and occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] r;
            case ($urandom_range(0, 5))
                0:       r = 16'h0000;
                1:       r = 16'h8000;
                2:       r = 16'h7fff;
                default: r = WIDTH'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, r, 2'($urandom), 3'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 2) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
        drive(1'b0, 16'h0, 2'b00, 3'd0, 1'b0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
